// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// instruction classes, opcode/funct values and datapath select codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI,
        C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILLEGAL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_LUI  = 4'd3;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_RA   = 2'd2;

    localparam logic [1:0] DAT_ALUOUT = 2'd0;
    localparam logic [1:0] DAT_MDR    = 2'd1;
    localparam logic [1:0] DAT_PC     = 2'd2;

    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_RS  = 1'b1;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_BOFS = 2'd3;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps the latched IR onto the class
// the control FSM dispatches on, flagging anything unsupported.
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] i_instr,
    output iclass_t     o_iclass,
    output logic        o_illegal
);

    logic [5:0] w_op;
    logic [5:0] w_funct;

    assign w_op    = i_instr[31:26];
    assign w_funct = i_instr[5:0];

    always_comb begin
        o_iclass = C_ILLEGAL;
        case (w_op)
            OP_RTYPE: begin
                // An all-zero word is the canonical nop, checked before funct.
                if (i_instr == 32'd0) begin
                    o_iclass = C_NOP;
                end else begin
                    case (w_funct)
                        FN_ADDU: o_iclass = C_ADDU;
                        FN_SUBU: o_iclass = C_SUBU;
                        FN_JR:   o_iclass = C_JR;
                        default: o_iclass = C_ILLEGAL;
                    endcase
                end
            end
            OP_ORI:  o_iclass = C_ORI;
            OP_LUI:  o_iclass = C_LUI;
            OP_LW:   o_iclass = C_LW;
            OP_SW:   o_iclass = C_SW;
            OP_BEQ:  o_iclass = C_BEQ;
            OP_J:    o_iclass = C_J;
            OP_JAL:  o_iclass = C_JAL;
            default: o_iclass = C_ILLEGAL;
        endcase
    end

    assign o_illegal = (o_iclass == C_ILLEGAL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the shared ALU/memory datapath
// through fetch, decode, execute, memory and write-back.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        gf_we,
    output logic [1:0]  gf_dst_sel,
    output logic [1:0]  gf_data_sel,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ext_op,
    output logic [3:0]  alu_op,
    output logic [3:0]  state,
    output logic        illegal
);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_illegal;
    iclass_t    w_iclass;
    logic       w_dec_illegal;

    logic       w_mem_req, w_mem_we, w_iord, w_ir_we, w_pc_we, w_gf_we;
    logic       w_alu_src_a, w_ext_op;
    logic [1:0] w_pc_src, w_gf_dst_sel, w_gf_data_sel, w_alu_src_b;
    logic [3:0] w_alu_op;

    mc_decode u_decode (
        .i_instr   (instr),
        .o_iclass  (w_iclass),
        .o_illegal (w_dec_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= state_t'(RESET_STATE);
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE && w_dec_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_iord        = 1'b0;
        w_ir_we       = 1'b0;
        w_pc_we       = 1'b0;
        w_pc_src      = PC_ALU;
        w_gf_we       = 1'b0;
        w_gf_dst_sel  = DST_RT;
        w_gf_data_sel = DAT_ALUOUT;
        w_alu_src_a   = SRCA_PC;
        w_alu_src_b   = SRCB_RT;
        w_ext_op      = 1'b0;
        w_alu_op      = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = SRCB_FOUR;
                // IR and PC load only on the acknowledge cycle.
                if (mem_ready) begin
                    w_ir_we      = 1'b1;
                    w_pc_we      = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_b = SRCB_BOFS;
                case (w_iclass)
                    C_ADDU, C_SUBU:  w_state_next = S_EXEC_R;
                    C_ORI, C_LUI:    w_state_next = S_EXEC_I;
                    C_LW, C_SW:      w_state_next = S_MEM_ADDR;
                    C_BEQ:           w_state_next = S_BRANCH;
                    C_J, C_JAL, C_JR: w_state_next = S_JUMP;
                    default:         w_state_next = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                w_alu_src_a  = SRCA_RS;
                w_alu_src_b  = SRCB_RT;
                w_alu_op     = (w_iclass == C_SUBU) ? ALU_SUB : ALU_ADD;
                w_state_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                // ori needs rs on A; lui ignores A, so both share the select.
                w_alu_src_a  = SRCA_RS;
                w_alu_src_b  = SRCB_IMM;
                w_alu_op     = (w_iclass == C_LUI) ? ALU_LUI : ALU_OR;
                w_state_next = S_WB_ALU;
            end
            S_WB_ALU: begin
                w_gf_we       = 1'b1;
                w_gf_dst_sel  = (w_iclass == C_ADDU || w_iclass == C_SUBU) ? DST_RD : DST_RT;
                w_gf_data_sel = DAT_ALUOUT;
                w_state_next  = S_FETCH;
            end
            S_MEM_ADDR: begin
                w_alu_src_a  = SRCA_RS;
                w_alu_src_b  = SRCB_IMM;
                w_ext_op     = 1'b1;
                w_state_next = (w_iclass == C_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                if (mem_ready) w_state_next = S_WB_MEM;
            end
            S_MEM_WR: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_mem_we  = 1'b1;
                if (mem_ready) w_state_next = S_FETCH;
            end
            S_WB_MEM: begin
                w_gf_we       = 1'b1;
                w_gf_dst_sel  = DST_RT;
                w_gf_data_sel = DAT_MDR;
                w_state_next  = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a  = SRCA_RS;
                w_alu_src_b  = SRCB_RT;
                w_alu_op     = ALU_SUB;
                w_pc_src     = PC_ALUOUT;
                w_pc_we      = zero;
                w_state_next = S_FETCH;
            end
            S_JUMP: begin
                w_pc_we  = 1'b1;
                w_pc_src = (w_iclass == C_JR) ? PC_RS : PC_JUMP;
                if (w_iclass == C_JAL) begin
                    w_gf_we       = 1'b1;
                    w_gf_dst_sel  = DST_RA;
                    w_gf_data_sel = DAT_PC;
                end
                w_state_next = S_FETCH;
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    // Outputs are held at zero for the whole time reset is low, so an
    // in-flight memory request is dropped immediately.
    assign mem_req     = reset & w_mem_req;
    assign mem_we      = reset & w_mem_we;
    assign iord        = reset & w_iord;
    assign ir_we       = reset & w_ir_we;
    assign pc_we       = reset & w_pc_we;
    assign gf_we       = reset & w_gf_we;
    assign alu_src_a   = reset & w_alu_src_a;
    assign ext_op      = reset & w_ext_op;
    assign pc_src      = reset ? w_pc_src      : 2'd0;
    assign gf_dst_sel  = reset ? w_gf_dst_sel  : 2'd0;
    assign gf_data_sel = reset ? w_gf_data_sel : 2'd0;
    assign alu_src_b   = reset ? w_alu_src_b   : 2'd0;
    assign alu_op      = reset ? w_alu_op      : 4'd0;
    assign state       = reset ? r_state       : 4'd0;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: the driver queues a hand-computed output
// vector for every cycle it drives, and a negedge monitor pops and compares.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_we, pc_we, gf_we, alu_src_a, ext_op, illegal;
    logic [1:0]  pc_src, gf_dst_sel, gf_data_sel, alu_src_b;
    logic [3:0]  alu_op, state;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .gf_we(gf_we), .gf_dst_sel(gf_dst_sel), .gf_data_sel(gf_data_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op),
        .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       req, we, iord, irw, pcw;
        logic [1:0] pcs;
        logic       gfw;
        logic [1:0] dst, dat;
        logic       a;
        logic [1:0] b;
        logic       ext;
        logic [3:0] alu;
        logic       ill;
    } obs_t;

    function automatic obs_t v(input logic [3:0] st, input logic req, input logic we,
                               input logic io, input logic irw, input logic pcw,
                               input logic [1:0] pcs, input logic gfw, input logic [1:0] dst,
                               input logic [1:0] dat, input logic a, input logic [1:0] b,
                               input logic ext, input logic [3:0] alu, input logic ill);
        obs_t o;
        o = {st, req, we, io, irw, pcw, pcs, gfw, dst, dat, a, b, ext, alu, ill};
        return o;
    endfunction

    obs_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad = 0;
    logic  chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            obs_t  got, e;
            string t;
            got = v(state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, gf_we, gf_dst_sel,
                    gf_data_sel, alu_src_a, alu_src_b, ext_op, alu_op, illegal);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL underflow: got=%h required=<queued vector>", got);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL %s: got=%h required=%h", t, got, e);
                end else begin
                    $display("chk %s state=%0d ok", t, state);
                end
            end
        end
    end

    task automatic step(input string tag, input obs_t e, input logic rdy);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        mem_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Hand-written rows. Fields: st req we iord irw pcw pcs gfw dst dat a b ext alu ill
    localparam logic [31:0] I_ADDU = 32'h0022_1821;   // addu $3,$1,$2
    localparam logic [31:0] I_LW   = 32'h8C24_0008;   // lw   $4,8($1)
    localparam logic [31:0] I_SW   = 32'hAC24_0000;   // sw   $4,0($1)
    localparam logic [31:0] I_BEQ  = 32'h1022_0004;   // beq  $1,$2,4
    localparam logic [31:0] I_JAL  = 32'h0C10_0004;   // jal  0x0040_0010
    localparam logic [31:0] I_JR   = 32'h03E0_0008;   // jr   $31
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;   // opcode 0x3F
    localparam logic [31:0] I_ORI  = 32'h3405_1234;   // ori  $5,$0,0x1234

    obs_t z_row, f0, f1, d0, d1;

    initial begin
        z_row = v(0, 0,0,0,0,0, 0, 0,0,0, 0,0,0,0, 0);
        f0    = v(0, 1,0,0,1,1, 0, 0,0,0, 0,1,0,0, 0);
        f1    = v(0, 1,0,0,1,1, 0, 0,0,0, 0,1,0,0, 1);
        d0    = v(1, 0,0,0,0,0, 0, 0,0,0, 0,3,0,0, 0);
        d1    = v(1, 0,0,0,0,0, 0, 0,0,0, 0,3,0,0, 1);

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step("reset", z_row, 1'b1);
        reset = 1'b1;

        step("addu fetch", f0, 1'b1);  instr = I_ADDU;
        step("addu decode", d0, 1'b1);
        step("addu exec", v(2, 0,0,0,0,0, 0, 0,0,0, 1,0,0,0, 0), 1'b1);
        step("addu wb", v(7, 0,0,0,0,0, 0, 1,1,0, 0,0,0,0, 0), 1'b1);

        step("lw fetch", f0, 1'b1);  instr = I_LW;
        step("lw decode", d0, 1'b1);
        step("lw addr", v(4, 0,0,0,0,0, 0, 0,0,0, 1,2,1,0, 0), 1'b1);
        step("lw rd wait1", v(5, 1,0,1,0,0, 0, 0,0,0, 0,0,0,0, 0), 1'b0);
        step("lw rd wait2", v(5, 1,0,1,0,0, 0, 0,0,0, 0,0,0,0, 0), 1'b0);
        step("lw rd ack", v(5, 1,0,1,0,0, 0, 0,0,0, 0,0,0,0, 0), 1'b1);
        step("lw wb", v(8, 0,0,0,0,0, 0, 1,0,1, 0,0,0,0, 0), 1'b1);

        zero = 1'b0;
        step("beq0 fetch", f0, 1'b1);  instr = I_BEQ;
        step("beq0 decode", d0, 1'b1);
        step("beq0 branch", v(9, 0,0,0,0,0, 1, 0,0,0, 1,0,0,1, 0), 1'b1);
        zero = 1'b1;
        step("beq1 fetch", f0, 1'b1);
        step("beq1 decode", d0, 1'b1);
        step("beq1 branch", v(9, 0,0,0,0,1, 1, 0,0,0, 1,0,0,1, 0), 1'b1);
        zero = 1'b0;

        step("jal fetch", f0, 1'b1);  instr = I_JAL;
        step("jal decode", d0, 1'b1);
        step("jal jump", v(10, 0,0,0,0,1, 2, 1,2,2, 0,0,0,0, 0), 1'b1);
        step("jr fetch", f0, 1'b1);  instr = I_JR;
        step("jr decode", d0, 1'b1);
        step("jr jump", v(10, 0,0,0,0,1, 3, 0,0,0, 0,0,0,0, 0), 1'b1);

        step("bad fetch", f0, 1'b1);  instr = I_BAD;
        step("bad decode", d0, 1'b1);
        step("ori fetch", f1, 1'b1);  instr = I_ORI;
        step("ori decode", d1, 1'b1);
        step("ori exec", v(3, 0,0,0,0,0, 0, 0,0,0, 1,2,0,2, 1), 1'b1);
        step("ori wb", v(7, 0,0,0,0,0, 0, 1,0,0, 0,0,0,0, 1), 1'b1);

        step("sw fetch", f1, 1'b1);  instr = I_SW;
        step("sw decode", d1, 1'b1);
        step("sw addr", v(4, 0,0,0,0,0, 0, 0,0,0, 1,2,1,0, 1), 1'b1);
        step("sw wr wait", v(6, 1,1,1,0,0, 0, 0,0,0, 0,0,0,0, 1), 1'b0);
        step("sw wr ack", v(6, 1,1,1,0,0, 0, 0,0,0, 0,0,0,0, 1), 1'b1);

        step("lw2 fetch", f1, 1'b1);  instr = I_LW;
        step("lw2 decode", d1, 1'b1);
        step("lw2 addr", v(4, 0,0,0,0,0, 0, 0,0,0, 1,2,1,0, 1), 1'b1);
        step("lw2 rd wait", v(5, 1,0,1,0,0, 0, 0,0,0, 0,0,0,0, 1), 1'b0);
        reset = 1'b0;
        step("reset mid rd", z_row, 1'b0);
        step("reset hold", z_row, 1'b0);
        reset = 1'b1;
        step("post-reset fetch", f0, 1'b1);  instr = 32'd0;
        step("nop decode", d0, 1'b1);
        step("nop back to fetch", f0, 1'b1);

        chk_en = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got=%0d queued required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
